// File: rtl/timer_irq_ctrl_if.sv
// CPU data-bus view of the timer register block.
// master drives address/strobes, slave returns rdata.
interface timer_irq_ctrl_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] rdata;

  modport master (
    output addr,
    output wdata,
    output mem_write,
    output mem_read,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wdata,
    input  mem_write,
    input  mem_read,
    output rdata
  );
endinterface

// File: rtl/timer_irq_ctrl.sv
// Memory-mapped reload timer (TH/TL/TCON) with an
// interrupt request FSM gated by kernel mode.
module timer_irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic              clk,
  input  logic              reset,
  timer_irq_ctrl_if.slave   bus,
  input  logic              kernel_mode,
  input  logic              irq_ack,
  output logic              irq
);

  localparam logic [31:0] TH_ADDR = BASE_ADDR;
  localparam logic [31:0] TL_ADDR = BASE_ADDR + 32'd4;
  localparam logic [31:0] TC_ADDR = BASE_ADDR + 32'd8;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    SERV
  } state_t;

  logic [31:0] th;
  logic [31:0] tl;
  logic        en;
  logic        ie;
  logic        st;
  state_t      state;
  state_t      state_nx;

  logic sel_th;
  logic sel_tl;
  logic sel_tc;
  logic wr_th;
  logic wr_tl;
  logic wr_tc;
  logic ovf;
  logic ovf_set;

  assign sel_th = (bus.addr == TH_ADDR);
  assign sel_tl = (bus.addr == TL_ADDR);
  assign sel_tc = (bus.addr == TC_ADDR);

  assign wr_th = bus.mem_write & sel_th;
  assign wr_tl = bus.mem_write & sel_tl;
  assign wr_tc = bus.mem_write & sel_tc;

  // Overflow replaces the increment with a reload.
  assign ovf     = en & (tl == 32'hFFFF_FFFF);
  assign ovf_set = ovf & ie;

  // Register file: TL write beats count/reload,
  // overflow status set beats a software clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      th <= '0;
      tl <= '0;
      en <= 1'b0;
      ie <= 1'b0;
      st <= 1'b0;
    end else begin
      if (wr_th) th <= bus.wdata;
      if (wr_tl)    tl <= bus.wdata;
      else if (ovf) tl <= th;
      else if (en)  tl <= tl + 32'd1;
      if (wr_tc) begin
        en <= bus.wdata[0];
        ie <= bus.wdata[1];
        st <= bus.wdata[2] | ovf_set;
      end else if (ovf_set) begin
        st <= 1'b1;
      end
    end
  end

  // Side-effect-free combinational read mux.
  always_comb begin
    bus.rdata = '0;
    if (bus.mem_read) begin
      unique case (1'b1)
        sel_th:  bus.rdata = th;
        sel_tl:  bus.rdata = tl;
        sel_tc:  bus.rdata = {29'd0, st, ie, en};
        default: bus.rdata = '0;
      endcase
    end
  end

  // Interrupt FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state; irq is a state decode masked
  // only by kernel_mode.
  always_comb begin
    state_nx = state;
    irq      = 1'b0;
    unique case (state)
      IDLE: begin
        if (st & ie) state_nx = PEND;
      end
      PEND: begin
        irq = ~kernel_mode;
        if (!st || !ie)
          state_nx = IDLE;
        else if (irq_ack && !kernel_mode)
          state_nx = SERV;
      end
      SERV: begin
        if (!st) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl: registers,
// reload, FSM, kernel masking and reset.
module tb_timer_irq_ctrl;

  localparam logic [31:0] B   = 32'h4000_0000;
  localparam logic [31:0] ATH = B;
  localparam logic [31:0] ATL = B + 32'd4;
  localparam logic [31:0] ATC = B + 32'd8;

  logic clk;
  logic reset;
  logic kernel_mode;
  logic irq_ack;
  logic irq;
  int   tests;
  int   fails;
  logic [31:0] d;

  timer_irq_ctrl_if bus ();

  timer_irq_ctrl #(.BASE_ADDR(B)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .kernel_mode (kernel_mode),
    .irq_ack     (irq_ack),
    .irq         (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] v);
    bus.addr      = a;
    bus.wdata     = v;
    bus.mem_write = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_write = 1'b0;
  endtask

  task automatic rd(input  logic [31:0] a,
                    output logic [31:0] v);
    bus.addr     = a;
    bus.mem_read = 1'b1;
    #1;
    v = bus.rdata;
    bus.mem_read = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick(1);
    wr(ATH, 32'h1234_5678);
    rd(ATH, d);
    tests++;
    if (d !== 32'h0) begin
      $display("FAIL rst_th got %h want 0", d);
      fails++;
    end
    rd(ATL, d);
    tests++;
    if (d !== 32'h0) begin
      $display("FAIL rst_tl got %h want 0", d);
      fails++;
    end
    rd(ATC, d);
    tests++;
    if (d !== 32'h0) begin
      $display("FAIL rst_tcon got %h want 0", d);
      fails++;
    end
    tests++;
    if (irq !== 1'b0) begin
      $display("FAIL rst_irq got %b want 0", irq);
      fails++;
    end
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_rw;
    wr(ATH, 32'hA5A5_5A5A);
    rd(ATH, d);
    tests++;
    if (d !== 32'hA5A5_5A5A) begin
      $display("FAIL rw_th got %h want a5a55a5a", d);
      fails++;
    end
    bus.addr = ATH;
    bus.mem_read = 1'b0;
    #1;
    tests++;
    if (bus.rdata !== 32'h0) begin
      $display("FAIL rw_noread got %h want 0",
               bus.rdata);
      fails++;
    end
    wr(ATL, 32'd100);
    wr(ATC, 32'hFFFF_FFFD);
    rd(ATC, d);
    tests++;
    if (d !== 32'h5) begin
      $display("FAIL rw_tcon got %h want 5", d);
      fails++;
    end
    rd(B + 32'd12, d);
    tests++;
    if (d !== 32'h0) begin
      $display("FAIL rw_unmapped got %h want 0", d);
      fails++;
    end
    tick(3);
    rd(ATL, d);
    tests++;
    if (d !== 32'd103) begin
      $display("FAIL cnt_inc got %0d want 103", d);
      fails++;
    end
    wr(ATC, 32'h0);
    tick(2);
    rd(ATL, d);
    tests++;
    if (d !== 32'd104) begin
      $display("FAIL cnt_hold got %0d want 104", d);
      fails++;
    end
  endtask

  task automatic test_overflow;
    wr(ATH, 32'hFFFF_FFF0);
    wr(ATL, 32'hFFFF_FFFE);
    wr(ATC, 32'h3);
    tick(1);
    rd(ATL, d);
    tests++;
    if (d !== 32'hFFFF_FFFF) begin
      $display("FAIL ovf_pre got %h want ffffffff", d);
      fails++;
    end
    tick(1);
    rd(ATL, d);
    tests++;
    if (d !== 32'hFFFF_FFF0) begin
      $display("FAIL ovf_reload got %h want fffffff0",
               d);
      fails++;
    end
    rd(ATC, d);
    tests++;
    if (d !== 32'h7 || irq !== 1'b0) begin
      $display("FAIL ovf_st tcon %h irq %b want 7/0",
               d, irq);
      fails++;
    end
    tick(1);
    tests++;
    if (irq !== 1'b1) begin
      $display("FAIL ovf_irq got %b want 1", irq);
      fails++;
    end
  endtask

  task automatic test_kernel_mask;
    wr(ATC, 32'h6);
    for (int i = 0; i < 3; i++) begin
      kernel_mode = 1'b1;
      tick(1);
      tests++;
      if (irq !== 1'b0) begin
        $display("FAIL kmask_%0d got %b want 0",
                 i, irq);
        fails++;
      end
    end
    kernel_mode = 1'b0;
    #1;
    tests++;
    if (irq !== 1'b1) begin
      $display("FAIL kmask_rel got %b want 1", irq);
      fails++;
    end
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    tests++;
    if (irq !== 1'b0) begin
      $display("FAIL ack_serv got %b want 0", irq);
      fails++;
    end
    tick(2);
    tests++;
    if (irq !== 1'b0) begin
      $display("FAIL serv_hold got %b want 0", irq);
      fails++;
    end
  endtask

  task automatic test_serv;
    wr(ATL, 32'hFFFF_FFFF);
    wr(ATC, 32'h7);
    tick(1);
    rd(ATL, d);
    tests++;
    if (d !== 32'hFFFF_FFF0 || irq !== 1'b0) begin
      $display("FAIL serv_ovf tl %h irq %b", d, irq);
      fails++;
    end
    tick(1);
    tests++;
    if (irq !== 1'b0) begin
      $display("FAIL serv_ovf2 got %b want 0", irq);
      fails++;
    end
    wr(ATC, 32'h3);
    rd(ATC, d);
    tests++;
    if (d !== 32'h3) begin
      $display("FAIL serv_clr got %h want 3", d);
      fails++;
    end
    wr(ATL, 32'hFFFF_FFFE);
    tick(1);
    wr(ATC, 32'h3);
    rd(ATC, d);
    tests++;
    if (d !== 32'h7 || irq !== 1'b0) begin
      $display("FAIL ovf_wins tcon %h irq %b", d, irq);
      fails++;
    end
    tick(1);
    tests++;
    if (irq !== 1'b1) begin
      $display("FAIL idle_pend got %b want 1", irq);
      fails++;
    end
  endtask

  task automatic test_tl_priority;
    wr(ATC, 32'h3);
    wr(ATL, 32'hFFFF_FFFE);
    tick(1);
    wr(ATL, 32'h0000_1234);
    rd(ATL, d);
    tests++;
    if (d !== 32'h0000_1234) begin
      $display("FAIL tl_prio got %h want 1234", d);
      fails++;
    end
    rd(ATC, d);
    tests++;
    if (d !== 32'h7) begin
      $display("FAIL tl_prio_st got %h want 7", d);
      fails++;
    end
    tick(1);
    rd(ATL, d);
    tests++;
    if (d !== 32'h0000_1235 || irq !== 1'b1) begin
      $display("FAIL tl_prio_nx tl %h irq %b", d, irq);
      fails++;
    end
  endtask

  task automatic test_reset_pend;
    wr(ATC, 32'h0);
    wr(ATL, 32'h0000_00AA);
    wr(ATC, 32'h6);
    tick(1);
    rd(ATL, d);
    tests++;
    if (d !== 32'hAA || irq !== 1'b1) begin
      $display("FAIL pre_rst tl %h irq %b", d, irq);
      fails++;
    end
    reset = 1'b0;
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    rd(ATL, d);
    tests++;
    if (d !== 32'h0) begin
      $display("FAIL rstp_tl got %h want 0", d);
      fails++;
    end
    rd(ATC, d);
    tests++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      $display("FAIL rstp_tcon %h irq %b", d, irq);
      fails++;
    end
    reset = 1'b1;
    tick(3);
    tests++;
    if (irq !== 1'b0) begin
      $display("FAIL rstp_after got %b want 0", irq);
      fails++;
    end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    reset         = 1'b0;
    kernel_mode   = 1'b0;
    irq_ack       = 1'b0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    tick(1);
    test_reset;
    test_rw;
    test_overflow;
    test_kernel_mask;
    test_serv;
    test_tl_priority;
    test_reset_pend;
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
